// File: rtl/urv_mem_sram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : urv_cfg / urv_typedef / urv_mem_sram_ctrl_pkg
// Description : Shared memory-bus configuration and types, plus local
//               constants and helpers for the SRAM controller.
// Revision    : 1.0 - initial release
// ============================================================================

package urv_cfg;
    localparam int MEM_ADDR_W  = 32;
    localparam int MEM_DATA_W  = 32;
    localparam int MEM_MASK_W  = MEM_DATA_W / 8;
    localparam int MEM_BURST_W = 4;
endpackage

package urv_typedef;
    import urv_cfg::*;

    typedef enum logic {
        MEM_READ  = 1'b0,
        MEM_WRITE = 1'b1
    } mem_req_type_t;

    typedef struct packed {
        mem_req_type_t            op;
        logic [MEM_ADDR_W-1:0]    addr;
        logic [MEM_MASK_W-1:0]    mask;
        logic [MEM_DATA_W-1:0]    data;
        logic [MEM_BURST_W-1:0]   burst;   // beats - 1
    } mem_req_t;

    typedef struct packed {
        mem_req_type_t            op;
        logic [MEM_DATA_W-1:0]    data;
        logic                     last;
    } mem_resp_t;
endpackage

package urv_mem_sram_ctrl_pkg;
    import urv_cfg::*;

    // Byte-offset bits dropped to form a word address
    localparam int c_word_off_w = $clog2(MEM_DATA_W / 8);
    // Beat counters hold up to 2^MEM_BURST_W beats
    localparam int c_beat_w     = MEM_BURST_W + 1;

    // Byte address to full-width word address; caller truncates to SRAM width
    function automatic logic [MEM_ADDR_W-1:0] word_of(input logic [MEM_ADDR_W-1:0] byte_addr);
        return byte_addr >> c_word_off_w;
    endfunction
endpackage

`default_nettype wire

// File: rtl/urv_mem_sram_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : urv_mem_sram_ctrl_if
// Description : Request/response handshake bundle between a memory master
//               and the SRAM controller.
// Revision    : 1.0 - initial release
// ============================================================================

interface urv_mem_sram_ctrl_if;
    import urv_typedef::*;

    logic      req_valid;
    logic      req_ready;
    mem_req_t  req;
    logic      resp_valid;
    logic      resp_ready;
    mem_resp_t resp;

    modport master (
        output req_valid, req, resp_ready,
        input  req_ready, resp_valid, resp
    );

    modport slave (
        input  req_valid, req, resp_ready,
        output req_ready, resp_valid, resp
    );
endinterface

`default_nettype wire

// File: rtl/urv_mem_sram_ctrl_resp_fifo.sv
`default_nettype none
// ============================================================================
// Module      : urv_mem_resp_fifo
// Description : Power-of-two response FIFO. A push while full is accepted
//               only when a pop happens in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================

module urv_mem_resp_fifo
    import urv_typedef::*;
#(
    parameter int DEPTH = 2
) (
    input  wire logic                    clk,
    input  wire logic                    rst_n,
    input  wire logic                    push,
    input  wire mem_resp_t               push_data,
    input  wire logic                    pop,
    output mem_resp_t                    head,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH):0]       count
);
    localparam int c_ptr_w = $clog2(DEPTH);
    localparam logic [c_ptr_w:0] c_depth = (c_ptr_w + 1)'(DEPTH);

    mem_resp_t          r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;
    logic               w_push;
    logic               w_pop;

    assign full   = (r_count == c_depth);
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign head   = r_mem[r_rd_ptr];
    assign w_pop  = pop && !empty;
    assign w_push = push && (!full || w_pop);

    // Storage: data needs no reset, validity lives in the counters
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

`default_nettype wire

// File: rtl/urv_mem_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : urv_mem_sram_ctrl
// Description : Burst-capable request/response front end for a single-port
//               synchronous SRAM with one-cycle read latency. Read issue is
//               credit-limited so returning data always has a FIFO slot.
// Revision    : 1.0 - initial release
// ============================================================================

module urv_mem_sram_ctrl
    import urv_cfg::*;
    import urv_typedef::*;
    import urv_mem_sram_ctrl_pkg::*;
#(
    parameter int SRAM_AW    = 12,
    parameter int RESP_DEPTH = 2
) (
    input  wire logic                   clk,
    input  wire logic                   rst_n,
    urv_mem_sram_ctrl_if.slave          bus,
    output logic                        sram_en,
    output logic                        sram_we,
    output logic [SRAM_AW-1:0]          sram_addr,
    output logic [MEM_MASK_W-1:0]       sram_wmask,
    output logic [MEM_DATA_W-1:0]       sram_wdata,
    input  wire logic [MEM_DATA_W-1:0]  sram_rdata
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD      = 2'd1,
        WR      = 2'd2,
        WR_RESP = 2'd3
    } state_t;

    state_t                      r_state;
    logic [SRAM_AW-1:0]          r_addr;
    logic [c_beat_w-1:0]         r_issue_left;  // reads to issue / write beats to accept
    logic [c_beat_w-1:0]         r_push_left;   // read beats still to land in the FIFO
    logic                        r_rd_vld;      // a read was issued last cycle

    state_t                      w_state_nxt;
    logic [SRAM_AW-1:0]          w_addr_nxt;
    logic [c_beat_w-1:0]         w_issue_nxt;
    logic [c_beat_w-1:0]         w_push_nxt;
    logic                        w_ready;
    logic                        w_en;
    logic                        w_we;
    logic                        w_rd_issue;
    logic [SRAM_AW-1:0]          w_sram_addr;
    logic [SRAM_AW-1:0]          w_req_word;
    logic [c_beat_w-1:0]         w_req_beats;
    logic                        w_credit;
    logic                        w_fifo_push;
    mem_resp_t                   w_fifo_push_data;
    mem_resp_t                   w_fifo_head;
    logic                        w_fifo_full;
    logic                        w_fifo_empty;
    logic [$clog2(RESP_DEPTH):0] w_fifo_count;

    assign w_req_word  = SRAM_AW'(word_of(bus.req.addr));
    assign w_req_beats = c_beat_w'({1'b0, bus.req.burst}) + c_beat_w'(1);
    // Occupancy plus in-flight read must leave room for the next returning word
    assign w_credit    = (int'(w_fifo_count) + int'(r_rd_vld)) < RESP_DEPTH;

    // Next-state, counter updates and SRAM strobes
    always_comb begin
        w_state_nxt      = r_state;
        w_addr_nxt       = r_addr;
        w_issue_nxt      = r_issue_left;
        w_push_nxt       = r_push_left;
        w_ready          = 1'b0;
        w_en             = 1'b0;
        w_we             = 1'b0;
        w_rd_issue       = 1'b0;
        w_sram_addr      = r_addr;
        w_fifo_push      = 1'b0;
        w_fifo_push_data = '0;

        unique case (r_state)
            IDLE: begin
                w_ready = 1'b1;
                if (bus.req_valid) begin
                    if (bus.req.op == MEM_WRITE) begin
                        // Beat 0 goes straight to the SRAM in the handshake cycle
                        w_en        = 1'b1;
                        w_we        = 1'b1;
                        w_sram_addr = w_req_word;
                        w_addr_nxt  = w_req_word + 1'b1;
                        w_issue_nxt = c_beat_w'({1'b0, bus.req.burst});
                        w_state_nxt = (bus.req.burst == '0) ? WR_RESP : WR;
                    end else begin
                        w_addr_nxt  = w_req_word;
                        w_issue_nxt = w_req_beats;
                        w_push_nxt  = w_req_beats;
                        w_state_nxt = RD;
                    end
                end
            end
            RD: begin
                if ((r_issue_left != '0) && w_credit) begin
                    w_en        = 1'b1;
                    w_rd_issue  = 1'b1;
                    w_addr_nxt  = r_addr + 1'b1;
                    w_issue_nxt = r_issue_left - 1'b1;
                end
                if (r_rd_vld) begin
                    w_fifo_push           = 1'b1;
                    w_fifo_push_data.op   = MEM_READ;
                    w_fifo_push_data.data = sram_rdata;
                    w_fifo_push_data.last = (r_push_left == c_beat_w'(1));
                    w_push_nxt            = r_push_left - 1'b1;
                    if (r_push_left == c_beat_w'(1)) begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            WR: begin
                w_ready = 1'b1;
                if (bus.req_valid) begin
                    w_en        = 1'b1;
                    w_we        = 1'b1;
                    w_addr_nxt  = r_addr + 1'b1;
                    w_issue_nxt = r_issue_left - 1'b1;
                    if (r_issue_left == c_beat_w'(1)) begin
                        w_state_nxt = WR_RESP;
                    end
                end
            end
            WR_RESP: begin
                if (!w_fifo_full) begin
                    w_fifo_push           = 1'b1;
                    w_fifo_push_data.op   = MEM_WRITE;
                    w_fifo_push_data.data = '0;
                    w_fifo_push_data.last = 1'b1;
                    w_state_nxt           = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State, address/beat counters and read-in-flight tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_addr       <= '0;
            r_issue_left <= '0;
            r_push_left  <= '0;
            r_rd_vld     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_addr       <= w_addr_nxt;
            r_issue_left <= w_issue_nxt;
            r_push_left  <= w_push_nxt;
            r_rd_vld     <= w_rd_issue;
        end
    end

    urv_mem_resp_fifo #(
        .DEPTH     (RESP_DEPTH)
    ) u_resp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_fifo_push),
        .push_data (w_fifo_push_data),
        .pop       (bus.resp_ready),
        .head      (w_fifo_head),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .count     (w_fifo_count)
    );

    // Outputs are held quiet while reset is asserted
    assign bus.req_ready  = rst_n && w_ready;
    assign bus.resp_valid = rst_n && !w_fifo_empty;
    assign bus.resp       = w_fifo_head;
    assign sram_en        = rst_n && w_en;
    assign sram_we        = rst_n && w_we;
    assign sram_addr      = w_sram_addr;
    assign sram_wmask     = w_we ? bus.req.mask : '0;
    assign sram_wdata     = bus.req.data;
endmodule

`default_nettype wire
